// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: owns the single write port of the 32 x 32-bit
// register file. After reset, or when asked, it writes zero to registers
// 1..31 one per cycle. It then shares the port between two writeback
// requesters with round-robin valid/ready arbitration. Read addresses that
// hit the write currently presented to the regfile are flagged as hazards.
module regfile_write_arbiter #(
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_clear,
  input  logic              req0_valid,
  input  logic [REG_W-1:0]  req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  input  logic [REG_W-1:0]  req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              ctrl_writeEn,
  output logic [REG_W-1:0]  ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  input  logic [REG_W-1:0]  ctrl_readRegA,
  input  logic [REG_W-1:0]  ctrl_readRegB,
  output logic              hazardA,
  output logic              hazardB,
  output logic              init_done
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_ARB   = 1'b1;

  localparam logic [REG_W-1:0] IDX_ONE  = {{(REG_W-1){1'b0}}, 1'b1};
  localparam logic [REG_W-1:0] IDX_LAST = {REG_W{1'b1}};

  logic [0:0]        state_q,      state_d;
  logic [REG_W-1:0]  idx_q,        idx_d;
  // Last requester served: 0 = req0, 1 = req1.
  logic              last_grant_q, last_grant_d;
  logic              init_done_q,  init_done_d;
  logic              we_q,         we_d;
  logic [REG_W-1:0]  wreg_q,       wreg_d;
  logic [DATA_W-1:0] wdata_q,      wdata_d;

  logic grant0;
  logic grant1;

  // Round-robin grant from the live request lines; nothing is granted
  // while zeroing or in the cycle a clear is requested.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned, which would infer a latch.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == ST_ARB && !ctrl_clear) begin
      if (req0_valid && req1_valid) begin
        if (last_grant_q) grant0 = 1'b1;
        else              grant1 = 1'b1;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Next-state logic: zeroing walk in CLEAR, handshake capture in ARB.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    last_grant_d = last_grant_q;
    init_done_d  = init_done_q;
    we_d         = 1'b0;
    wreg_d       = wreg_q;
    wdata_d      = wdata_q;

    case (state_q)
      ST_CLEAR: begin
        // ctrl_clear has no effect here; the walk always runs to the end.
        we_d    = 1'b1;
        wreg_d  = idx_q;
        wdata_d = '0;
        idx_d   = idx_q + IDX_ONE;
        if (idx_q == IDX_LAST) begin
          state_d     = ST_ARB;
          init_done_d = 1'b1;
        end
      end
      ST_ARB: begin
        if (ctrl_clear) begin
          state_d     = ST_CLEAR;
          idx_d       = IDX_ONE;
          init_done_d = 1'b0;
        end else if (grant0) begin
          // Register 0 is hardwired: the handshake completes, the write is dropped.
          wreg_d       = req0_reg;
          wdata_d      = req0_data;
          we_d         = (req0_reg != '0);
          last_grant_d = 1'b0;
        end else if (grant1) begin
          wreg_d       = req1_reg;
          wdata_d      = req1_data;
          we_d         = (req1_reg != '0);
          last_grant_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_CLEAR;
        idx_d       = IDX_ONE;
        init_done_d = 1'b0;
      end
    endcase
  end

  // State and regfile-port registers; reset aborts any walk or pending write.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state_q      <= ST_CLEAR;
      idx_q        <= IDX_ONE;
      last_grant_q <= 1'b1;
      init_done_q  <= 1'b0;
      we_q         <= 1'b0;
      wreg_q       <= '0;
      wdata_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // values from before this edge, independent of statement order.
      state_q      <= state_d;
      idx_q        <= idx_d;
      last_grant_q <= last_grant_d;
      init_done_q  <= init_done_d;
      we_q         <= we_d;
      wreg_q       <= wreg_d;
      wdata_q      <= wdata_d;
    end
  end

  assign ctrl_writeEn  = we_q;
  assign ctrl_writeReg = wreg_q;
  assign data_writeReg = wdata_q;
  assign init_done     = init_done_q;

  // A read of a register whose write is presented this cycle sees stale
  // data from the array; register 0 never hazards since it never changes.
  assign hazardA = we_q & (ctrl_readRegA == wreg_q) & (ctrl_readRegA != '0);
  assign hazardB = we_q & (ctrl_readRegB == wreg_q) & (ctrl_readRegB != '0);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed sequences, a vector table
// for arbitration order, and randomized traffic against a transaction-level
// model of the write port plus a model of the register file contents.
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        ctrl_clear;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_reg, req1_reg;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        ctrl_writeEn;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA, ctrl_readRegB;
  logic        hazardA, hazardB;
  logic        init_done;

  regfile_write_arbiter #(.REG_W(5), .DATA_W(32)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_clear(ctrl_clear),
    .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .ctrl_writeEn(ctrl_writeEn), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .hazardA(hazardA), .hazardB(hazardB), .init_done(init_done)
  );

  always #5 clock = ~clock;

  // Register file driven by the DUT's write port (commits on the edge).
  logic [31:0] rf [32] = '{default: 32'hA5A5_A5A5};
  always @(posedge clock) if (ctrl_writeEn) rf[ctrl_writeReg] <= data_writeReg;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_arb;       // zeroing finished, arbitrating
  int          m_idx;       // next register the zeroing walk writes
  int          m_last;      // requester served most recently
  bit          m_we;
  int          m_reg;
  logic [31:0] m_data;
  logic [31:0] mem [32] = '{default: 32'hA5A5_A5A5};
  int          cur_g;

  task automatic model_reset();
    m_arb = 0; m_idx = 1; m_last = 1; m_we = 0; m_reg = 0; m_data = 32'h0;
  endtask

  // Who gets the port this cycle: -1 none, else requester index.
  function automatic int model_grant();
    if (!m_arb || ctrl_clear) return -1;
    if (req0_valid && req1_valid) return 1 - m_last;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  // Settle combinational outputs and compare against the model.
  task automatic pre_edge();
    bit ha, hb;
    #1;
    cur_g = model_grant();
    ha = m_we && (int'(ctrl_readRegA) == m_reg) && (ctrl_readRegA != 0);
    hb = m_we && (int'(ctrl_readRegB) == m_reg) && (ctrl_readRegB != 0);
    check("m_ready0", 32'(req0_ready), 32'(cur_g == 0));
    check("m_ready1", 32'(req1_ready), 32'(cur_g == 1));
    check("m_hazardA", 32'(hazardA), 32'(ha));
    check("m_hazardB", 32'(hazardB), 32'(hb));
  endtask

  // Clock edge: advance the model and compare registered outputs.
  task automatic edge_step();
    @(posedge clock);
    if (m_we && m_reg != 0) mem[m_reg] = m_data;
    if (!m_arb) begin
      m_we = 1; m_reg = m_idx; m_data = 32'h0;
      if (m_idx == 31) m_arb = 1;
      m_idx++;
    end else if (ctrl_clear) begin
      m_arb = 0; m_idx = 1; m_we = 0;
    end else if (cur_g == 0) begin
      m_reg = int'(req0_reg); m_data = req0_data; m_we = (req0_reg != 0); m_last = 0;
    end else if (cur_g == 1) begin
      m_reg = int'(req1_reg); m_data = req1_data; m_we = (req1_reg != 0); m_last = 1;
    end else begin
      m_we = 0;
    end
    #1;
    check("m_writeEn", 32'(ctrl_writeEn), 32'(m_we));
    check("m_writeReg", 32'(ctrl_writeReg), 32'(m_reg));
    check("m_data", data_writeReg, m_data);
    check("m_init_done", 32'(init_done), 32'(m_arb));
  endtask

  task automatic cycle();
    pre_edge();
    edge_step();
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; ctrl_clear = 0;
  endtask

  task automatic wait_init(input string nm);
    for (int n = 0; n < 40 && !m_arb; n++) cycle();
    check(nm, 32'(init_done), 32'h1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic v0; logic [4:0] r0; logic [31:0] d0;
    logic v1; logic [4:0] r1; logic [31:0] d1;
    logic rdy0; logic rdy1; logic we; logic [4:0] wreg; logic [31:0] wdata;
  } vec_t;
  vec_t tbl [11];

  initial begin
    // Starts with last grant = req1, so req0 is served first.
    tbl[0]  = '{1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b1, 1'b0, 1'b1, 5'd3,  32'h11};
    tbl[1]  = '{1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 1'b1, 1'b1, 5'd4,  32'h22};
    tbl[2]  = '{1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b1, 1'b0, 1'b1, 5'd3,  32'h11};
    tbl[3]  = '{1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 1'b1, 1'b1, 5'd4,  32'h22};
    tbl[4]  = '{1'b1, 5'd7, 32'h70, 1'b1, 5'd7, 32'h71, 1'b1, 1'b0, 1'b1, 5'd7,  32'h70};
    tbl[5]  = '{1'b1, 5'd7, 32'h70, 1'b1, 5'd7, 32'h71, 1'b0, 1'b1, 1'b1, 5'd7,  32'h71};
    tbl[6]  = '{1'b1, 5'd7, 32'h70, 1'b1, 5'd7, 32'h71, 1'b1, 1'b0, 1'b1, 5'd7,  32'h70};
    tbl[7]  = '{1'b1, 5'd7, 32'h70, 1'b1, 5'd7, 32'h71, 1'b0, 1'b1, 1'b1, 5'd7,  32'h71};
    tbl[8]  = '{1'b0, 5'd1, 32'h99, 1'b0, 5'd2, 32'h98, 1'b0, 1'b0, 1'b0, 5'd7,  32'h71};
    tbl[9]  = '{1'b0, 5'd1, 32'h99, 1'b1, 5'd10, 32'h1010, 1'b0, 1'b1, 1'b1, 5'd10, 32'h1010};
    tbl[10] = '{1'b1, 5'd0, 32'h5,  1'b0, 5'd2, 32'h98, 1'b1, 1'b0, 1'b0, 5'd0,  32'h5};
  end

  // ---------------- test sequence ----------------
  initial begin
    bit hold0, hold1;
    ctrl_reset = 0; idle_inputs();
    req0_reg = 0; req0_data = 0; req1_reg = 0; req1_data = 0;
    ctrl_readRegA = 0; ctrl_readRegB = 0;
    model_reset();
    #1;
    check("rst_writeEn", 32'(ctrl_writeEn), 32'h0);
    check("rst_writeReg", 32'(ctrl_writeReg), 32'h0);
    check("rst_data", data_writeReg, 32'h0);
    check("rst_init_done", 32'(init_done), 32'h0);

    // Zeroing after reset, with both requesters pushing throughout.
    repeat (2) @(posedge clock);
    #1 ctrl_reset = 1;
    req0_valid = 1; req0_reg = 5'd2; req0_data = 32'h77;
    req1_valid = 1; req1_reg = 5'd8; req1_data = 32'h88;
    for (int k = 1; k <= 31; k++) begin
      pre_edge();
      check("zero_ready0", 32'(req0_ready), 32'h0);
      check("zero_ready1", 32'(req1_ready), 32'h0);
      edge_step();
      check("zero_reg", 32'(ctrl_writeReg), 32'(k));
      check("zero_data", data_writeReg, 32'h0);
      check("zero_we", 32'(ctrl_writeEn), 32'h1);
    end
    check("zero_init_done", 32'(init_done), 32'h1);
    idle_inputs();
    cycle();
    for (int i = 1; i < 32; i++) check($sformatf("zero_rf%0d", i), rf[i], 32'h0);

    // Single requester.
    req0_valid = 1; req0_reg = 5'd5; req0_data = 32'h0000_DEAD;
    pre_edge();
    check("single_ready0", 32'(req0_ready), 32'h1);
    edge_step();
    check("single_we", 32'(ctrl_writeEn), 32'h1);
    check("single_reg", 32'(ctrl_writeReg), 32'd5);
    check("single_data", data_writeReg, 32'h0000_DEAD);
    idle_inputs();
    cycle();
    check("single_rf5", rf[5], 32'h0000_DEAD);

    // Register 0 write: handshake completes, write dropped.
    req1_valid = 1; req1_reg = 5'd0; req1_data = 32'hFFFF_FFFF;
    pre_edge();
    check("r0_ready1", 32'(req1_ready), 32'h1);
    edge_step();
    check("r0_we", 32'(ctrl_writeEn), 32'h0);
    idle_inputs();
    cycle();
    check("r0_untouched", rf[0], 32'hA5A5_A5A5);

    // Arbitration order from the table.
    for (int i = 0; i < 11; i++) begin
      req0_valid = tbl[i].v0; req0_reg = tbl[i].r0; req0_data = tbl[i].d0;
      req1_valid = tbl[i].v1; req1_reg = tbl[i].r1; req1_data = tbl[i].d1;
      pre_edge();
      check($sformatf("tbl%0d_ready0", i), 32'(req0_ready), 32'(tbl[i].rdy0));
      check($sformatf("tbl%0d_ready1", i), 32'(req1_ready), 32'(tbl[i].rdy1));
      edge_step();
      check($sformatf("tbl%0d_we", i), 32'(ctrl_writeEn), 32'(tbl[i].we));
      check($sformatf("tbl%0d_reg", i), 32'(ctrl_writeReg), 32'(tbl[i].wreg));
      check($sformatf("tbl%0d_data", i), data_writeReg, tbl[i].wdata);
    end
    idle_inputs();
    cycle();
    check("cont_rf3", rf[3], 32'h11);
    check("cont_rf4", rf[4], 32'h22);
    check("cont_rf7_last", rf[7], 32'h71);
    check("cont_rf10", rf[10], 32'h1010);

    // Hazard flags during a write to register 6.
    req0_valid = 1; req0_reg = 5'd6; req0_data = 32'h66;
    cycle();
    idle_inputs();
    ctrl_readRegA = 5'd6; ctrl_readRegB = 5'd0;
    #1;
    check("haz_A", 32'(hazardA), 32'h1);
    check("haz_B", 32'(hazardB), 32'h0);
    cycle();
    check("haz_A_after", 32'(hazardA), 32'h0);

    // Clear mid-operation.
    req0_valid = 1; req0_reg = 5'd9; req0_data = 32'hBEEF;
    cycle();
    ctrl_clear = 1; req0_reg = 5'd12; req0_data = 32'h1234;
    pre_edge();
    check("clr_ready0", 32'(req0_ready), 32'h0);
    edge_step();
    check("clr_init_drop", 32'(init_done), 32'h0);
    check("clr_rf9_written", rf[9], 32'hBEEF);
    ctrl_clear = 0;
    wait_init("clr_timeout");
    check("clr_rf9_zero", rf[9], 32'h0);
    pre_edge();
    check("clr_ready0_after", 32'(req0_ready), 32'h1);
    edge_step();
    idle_inputs();

    // Reset in the middle of zeroing.
    ctrl_clear = 1;
    cycle();
    ctrl_clear = 0;
    for (int n = 0; n < 40 && m_idx != 12; n++) cycle();
    check("midrst_idx_reached", 32'(ctrl_writeReg), 32'd11);
    #2 ctrl_reset = 0;
    #1;
    model_reset();
    check("midrst_we", 32'(ctrl_writeEn), 32'h0);
    check("midrst_reg", 32'(ctrl_writeReg), 32'h0);
    check("midrst_data", data_writeReg, 32'h0);
    check("midrst_init", 32'(init_done), 32'h0);
    @(posedge clock);
    #1 ctrl_reset = 1;
    cycle();
    check("midrst_restart", 32'(ctrl_writeReg), 32'd1);
    wait_init("midrst_timeout");

    // Randomized traffic; requesters hold their request until served.
    hold0 = 0; hold1 = 0;
    for (int c = 0; c < 400; c++) begin
      if (!hold0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_reg = 5'($urandom); req0_data = $urandom;
      end
      if (!hold1) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_reg = 5'($urandom); req1_data = $urandom;
      end
      ctrl_clear = ($urandom_range(0, 59) == 0);
      ctrl_readRegA = ($urandom_range(0, 1) != 0) ? 5'(m_reg) : 5'($urandom);
      ctrl_readRegB = 5'($urandom);
      cycle();
      hold0 = req0_valid && (cur_g != 0);
      hold1 = req1_valid && (cur_g != 1);
    end
    idle_inputs();
    wait_init("rand_timeout");
    cycle();
    for (int i = 1; i < 32; i++) check($sformatf("final_rf%0d", i), rf[i], mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
